// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider, one quotient bit per clock.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst_a     - synchronous active-high reset, highest priority
//   dividend  - unsigned dividend, captured only on an accepted load
//   divisor   - unsigned divisor, captured only on an accepted load
//   load      - start request, accepted in IDLE or DONE
//   quo       - registered quotient of the last completed operation
//   rem       - registered remainder of the last completed operation
//   ready_out - quo/rem hold a valid result
//   busy      - an iteration sequence is in progress
//   div_zero  - last completed operation had divisor == 0
module seq_div #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    input  logic                  load,
    output logic [DIVIDEND_W-1:0] quo,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  ready_out,
    output logic                  busy,
    output logic                  div_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;   // dividend shifts out, quotient shifts in
    logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
    logic [DIVISOR_W:0]      pr_q, pr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0]   quo_q, quo_d;
    logic [DIVISOR_W-1:0]    rem_q, rem_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    dz_q, dz_d;

    logic [DIVISOR_W:0]      pr_sh;
    logic [DIVISOR_W:0]      pr_nx;
    logic                    q_bit;
    logic [DIVIDEND_W-1:0]   dvd_nx;

    // One restoring step computed from the current registers.
    always_comb begin
        pr_sh  = {pr_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
        q_bit  = (pr_sh >= {1'b0, dvs_q});
        pr_nx  = q_bit ? (pr_sh - {1'b0, dvs_q}) : pr_sh;
        dvd_nx = {dvd_q[DIVIDEND_W-2:0], q_bit};
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    pr_d    = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    dz_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (dvs_q == '0) begin
                    // Zero divisor: single bypass cycle, no iterations.
                    quo_d   = '1;
                    rem_d   = '0;
                    dz_d    = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    pr_d  = pr_nx;
                    dvd_d = dvd_nx;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                        quo_d   = dvd_nx;
                        rem_d   = pr_nx[DIVISOR_W-1:0];
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            dz_q    <= dz_d;
        end
    end

    assign quo       = quo_q;
    assign rem       = rem_q;
    assign ready_out = ready_q;
    assign busy      = busy_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed and randomized checks of seq_div against a plain
// arithmetic reference (integer / and %).
module tb_seq_div;

    logic       clk = 1'b0;
    logic       rst_a;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       load;
    logic [7:0] quo;
    logic [3:0] rem;
    logic       ready_out;
    logic       busy;
    logic       div_zero;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] prev_q = 8'd0;
    logic [3:0] prev_r = 4'd0;

    seq_div #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .dividend  (dividend),
        .divisor   (divisor),
        .load      (load),
        .quo       (quo),
        .rem       (rem),
        .ready_out (ready_out),
        .busy      (busy),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation; inj>0 pulses a stray load inj edges after the accept edge.
    task automatic run_op(input int a, input int b, input int inj);
        int exp_q, exp_r, lat, e;
        if (b == 0) begin
            exp_q = 255; exp_r = 0; lat = 1;
        end else begin
            exp_q = a / b; exp_r = a % b; lat = 8;
        end
        dividend = 8'(a);
        divisor  = 4'(b);
        load     = 1'b1;
        tick();
        load     = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        chk("accept_ready", {31'd0, ready_out}, 0);
        chk("accept_dz", {31'd0, div_zero}, 0);
        chk("accept_busy", {31'd0, busy}, 1);
        e = 0;
        while (!ready_out && e < 20) begin
            chk("calc_hold_quo", {24'd0, quo}, {24'd0, prev_q});
            chk("calc_hold_rem", {28'd0, rem}, {28'd0, prev_r});
            if (e == inj) begin
                load = 1'b1; dividend = 8'd50; divisor = 4'd3;
            end
            tick();
            load = 1'b0;
            e++;
        end
        chk("latency", e, lat);
        chk("quo", {24'd0, quo}, exp_q);
        chk("rem", {28'd0, rem}, exp_r);
        chk("div_zero", {31'd0, div_zero}, (b == 0) ? 1 : 0);
        chk("done_busy", {31'd0, busy}, 0);
        prev_q = 8'(exp_q);
        prev_r = 4'(exp_r);
    endtask

    initial begin
        rst_a = 1'b1; load = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        rst_a = 1'b0;
        chk("rst_quo", {24'd0, quo}, 0);
        chk("rst_rem", {28'd0, rem}, 0);
        chk("rst_ready", {31'd0, ready_out}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_dz", {31'd0, div_zero}, 0);

        // Basic and boundary operands.
        run_op(100, 7, -1);
        run_op(255, 1, -1);
        run_op(15, 15, -1);
        run_op(3, 9, -1);

        // Result holds in DONE with load low.
        repeat (3) tick();
        chk("hold_ready", {31'd0, ready_out}, 1);
        chk("hold_quo", {24'd0, quo}, 0);
        chk("hold_rem", {28'd0, rem}, 3);

        // Divide by zero, then a legal load clears div_zero.
        run_op(9, 0, -1);
        run_op(200, 13, -1);

        // Stray load mid-calculation is ignored.
        run_op(100, 7, 4);
        // Load at the completion edge is ignored: DONE persists next cycle.
        run_op(77, 5, 7);
        tick();
        chk("cmpl_edge_load_ready", {31'd0, ready_out}, 1);
        chk("cmpl_edge_load_busy", {31'd0, busy}, 0);
        chk("cmpl_edge_load_quo", {24'd0, quo}, 15);

        // Reset mid-calculation discards the operation.
        dividend = 8'd200; divisor = 4'd13; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("midrst_quo", {24'd0, quo}, 0);
        chk("midrst_rem", {28'd0, rem}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_ready", {31'd0, ready_out}, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (ready_out || busy) seen++;
            end
            chk("midrst_no_completion", seen, 0);
        end
        prev_q = 8'd0; prev_r = 4'd0;
        run_op(100, 7, -1);

        // Random operations, zero divisor included.
        for (int i = 0; i < 40; i++)
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), -1);

        // Exhaustive back-to-back sweep of nonzero divisors.
        for (int b = 1; b < 16; b++)
            for (int a = 0; a < 256; a++)
                run_op(a, b, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
